// File: rtl/client_inject_queue.sv
// Injection buffer between a traffic client and a NoC router injection port.
// FWFT FIFO with a registered head, illegal-destination drop and per-port statistics.
module client_inject_queue #(
  parameter int N     = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int DEPTH = 4,
  parameter int posx  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_W+D_W:0]     c_i,
  input  logic                 c_i_v,
  output logic                 c_i_bp,
  output logic [A_W+D_W:0]     o,
  output logic                 o_v,
  input  logic                 o_bp,
  output logic [31:0]          in_cnt,
  output logic [31:0]          out_cnt,
  output logic [31:0]          drop_cnt,
  output logic [31:0]          stall_cnt,
  output logic                 err,
  output logic                 empty
);

  localparam int P_W   = $clog2(DEPTH);
  localparam int C_W   = P_W + 1;
  localparam int PKT_W = A_W + D_W + 1;
  localparam logic [A_W-1:0] L_N = A_W'(N);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || posx < 0) begin : g_bad_param
    $error("client_inject_queue: DEPTH must be a power of two >= 2 and posx >= 0");
  end

  typedef logic [PKT_W-1:0] pkt_t;

  // Handshake on both ports: a packet moves in a cycle where valid=1 and bp=0;
  // the sender keeps packet and valid stable for as long as bp=1.

  pkt_t             r_mem [DEPTH];
  logic [P_W-1:0]   r_wr_ptr;
  logic [P_W-1:0]   r_rd_ptr;
  logic [C_W-1:0]   r_count;
  pkt_t             r_o;
  logic             r_o_v;
  logic [31:0]      r_in_cnt;
  logic [31:0]      r_out_cnt;
  logic [31:0]      r_drop_cnt;
  logic [31:0]      r_stall_cnt;
  logic             r_err;
  logic             r_empty;

  logic             w_full;
  logic [A_W-1:0]   w_dest;
  logic             w_legal;
  logic             w_offer;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_stall;
  logic [C_W-1:0]   w_count_nxt;
  logic [C_W-1:0]   w_avail;
  logic [P_W-1:0]   w_head_ptr;
  logic             w_load;
  logic             w_refill;

  assign w_full   = (r_count == C_W'(DEPTH));
  assign w_dest   = c_i[A_W+D_W-1:D_W];
  assign w_legal  = (w_dest < L_N);
  assign w_offer  = c_i_v & ~w_full;
  assign w_push   = w_offer & w_legal;
  assign w_drop   = w_offer & ~w_legal;
  assign w_pop    = r_o_v & ~o_bp;
  assign w_stall  = r_o_v & o_bp;

  assign w_count_nxt = r_count + C_W'(w_push) - C_W'(w_pop);

  // The head register mirrors mem[rd_ptr]; entries pushed this cycle are not
  // visible yet, so a push never bypasses straight onto the output.
  assign w_avail    = r_count - C_W'(w_pop);
  assign w_head_ptr = w_pop ? (r_rd_ptr + P_W'(1)) : r_rd_ptr;
  assign w_refill   = ~r_o_v | w_pop;
  assign w_load     = w_refill & (w_avail != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= c_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_o         <= '0;
      r_o_v       <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + P_W'(1);
        r_in_cnt <= r_in_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + P_W'(1);
        r_out_cnt <= r_out_cnt + 32'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
        r_err      <= 1'b1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      if (w_load) begin
        r_o   <= r_mem[w_head_ptr];
        r_o_v <= 1'b1;
      end else if (w_refill) begin
        r_o_v <= 1'b0;
      end
    end
  end

  assign c_i_bp    = w_full;
  assign o         = r_o;
  assign o_v       = r_o_v;
  assign in_cnt    = r_in_cnt;
  assign out_cnt   = r_out_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign stall_cnt = r_stall_cnt;
  assign err       = r_err;
  assign empty     = r_empty;

endmodule

// File: tb/tb_client_inject_queue.sv
// Directed bench for client_inject_queue: N=4/DEPTH=4 main instance plus an
// N=3 instance for the destination-equals-N drop case.
module tb_client_inject_queue;

  localparam int D_W = 32;
  localparam int A_W = 3;
  localparam int PW  = A_W + D_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [PW-1:0] c_i;
  logic          c_i_v;
  logic          c_i_bp;
  logic [PW-1:0] o;
  logic          o_v;
  logic          o_bp;
  logic [31:0]   in_cnt, out_cnt, drop_cnt, stall_cnt;
  logic          err, empty;

  logic [PW-1:0] c3_i;
  logic          c3_v;
  logic          c3_bp;
  logic [PW-1:0] o3;
  logic          o3_v;
  logic          o3_bp;
  logic [31:0]   in3_cnt, out3_cnt, drop3_cnt, stall3_cnt;
  logic          err3, empty3;

  client_inject_queue #(.N(4), .D_W(D_W), .A_W(A_W), .DEPTH(4), .posx(0)) u_dut (
    .clk(clk), .rst(rst),
    .c_i(c_i), .c_i_v(c_i_v), .c_i_bp(c_i_bp),
    .o(o), .o_v(o_v), .o_bp(o_bp),
    .in_cnt(in_cnt), .out_cnt(out_cnt), .drop_cnt(drop_cnt), .stall_cnt(stall_cnt),
    .err(err), .empty(empty)
  );

  client_inject_queue #(.N(3), .D_W(D_W), .A_W(A_W), .DEPTH(4), .posx(1)) u_dut3 (
    .clk(clk), .rst(rst),
    .c_i(c3_i), .c_i_v(c3_v), .c_i_bp(c3_bp),
    .o(o3), .o_v(o3_v), .o_bp(o3_bp),
    .in_cnt(in3_cnt), .out_cnt(out3_cnt), .drop_cnt(drop3_cnt), .stall_cnt(stall3_cnt),
    .err(err3), .empty(empty3)
  );

  // scoreboard
  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [PW-1:0] mk(input logic f, input logic [A_W-1:0] d, input logic [31:0] p);
    return {f, d, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: record this cycle's handshakes on the main instance, then advance one edge
  task automatic cyc();
    logic [A_W-1:0] d;
    if (!rst) begin
      if (o_v && !o_bp) begin
        if (exp_q.size() == 0) chk("pop_q_empty", 64'(o_v), 64'd0);
        else                   chk("pop_order", 64'(o), 64'(exp_q.pop_front()));
      end
      d = c_i[A_W+D_W-1:D_W];
      if (c_i_v && !c_i_bp && d < 3'd4) exp_q.push_back(c_i);
    end
    @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] s_pkt [5];
  logic [PW-1:0] f_pkt [6];
  logic [PW-1:0] r_pkt;

  initial begin
    rst = 1'b1; c_i = '0; c_i_v = 1'b0; o_bp = 1'b0;
    c3_i = '0; c3_v = 1'b0; o3_bp = 1'b0;
    for (int k = 0; k < 5; k++) s_pkt[k] = mk(k[0], 3'((k % 3) + 1), 32'h10 + 32'(k));
    for (int j = 0; j < 6; j++) f_pkt[j] = mk(j[0], 3'(j % 4), 32'h20 + 32'(j));

    // reset then idle
    cyc(); cyc();
    chk("rst_ov", 64'(o_v), 64'd0);
    chk("rst_o", 64'(o), 64'd0);
    chk("rst_bp", 64'(c_i_bp), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_in", 64'(in_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    repeat (10) cyc();
    chk("idle_ov", 64'(o_v), 64'd0);
    chk("idle_empty", 64'(empty), 64'd1);
    chk("idle_cnts", 64'(in_cnt | out_cnt | drop_cnt | stall_cnt), 64'd0);

    // streaming, 5 back-to-back packets with no router backpressure
    c_i_v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c_i = s_pkt[k];
      cyc();
      chk("stream_bp", 64'(c_i_bp), 64'd0);
      if (k == 0) chk("stream_lat", 64'(o_v), 64'd0);
      else begin
        chk("stream_ov", 64'(o_v), 64'd1);
        chk("stream_o", 64'(o), 64'(s_pkt[k-1]));
        chk("stream_occ", 64'(32'(in_cnt - out_cnt)), 64'd2);
      end
    end
    c_i_v = 1'b0;
    cyc();
    chk("stream_last", 64'(o), 64'(s_pkt[4]));
    cyc();
    chk("stream_ov_end", 64'(o_v), 64'd0);
    chk("stream_empty", 64'(empty), 64'd1);
    chk("stream_in", 64'(in_cnt), 64'd5);
    chk("stream_out", 64'(out_cnt), 64'd5);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // fill with the router stalled
    o_bp = 1'b1; c_i_v = 1'b1;
    for (int j = 0; j < 4; j++) begin
      c_i = f_pkt[j];
      chk("fill_bp_pre", 64'(c_i_bp), 64'd0);
      cyc();
    end
    chk("fill_full", 64'(c_i_bp), 64'd1);
    chk("fill_in", 64'(in_cnt), 64'd9);
    chk("fill_stall", 64'(stall_cnt), 64'd2);
    chk("fill_head", 64'(o), 64'(f_pkt[0]));
    c_i = f_pkt[4];
    repeat (3) cyc();
    chk("full_stall", 64'(stall_cnt), 64'd5);
    chk("full_in", 64'(in_cnt), 64'd9);
    chk("full_bp", 64'(c_i_bp), 64'd1);
    // full with a pop: no push on this edge
    o_bp = 1'b0;
    cyc();
    chk("fullpop_bp", 64'(c_i_bp), 64'd0);
    chk("fullpop_in", 64'(in_cnt), 64'd9);
    chk("fullpop_out", 64'(out_cnt), 64'd6);
    chk("fullpop_o", 64'(o), 64'(f_pkt[1]));
    chk("fullpop_stall", 64'(stall_cnt), 64'd5);
    cyc();
    chk("refill_in", 64'(in_cnt), 64'd10);
    chk("refill_o", 64'(o), 64'(f_pkt[2]));
    c_i = f_pkt[5];
    cyc();
    chk("refill2_in", 64'(in_cnt), 64'd11);
    c_i_v = 1'b0;
    repeat (3) cyc();
    chk("drain_ov", 64'(o_v), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_out", 64'(out_cnt), 64'd11);

    // illegal destinations on the N=4 instance
    c_i = mk(1'b0, 3'd4, 32'hBAD); c_i_v = 1'b1;
    cyc();
    chk("ill_drop", 64'(drop_cnt), 64'd1);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_in", 64'(in_cnt), 64'd11);
    chk("ill_bp", 64'(c_i_bp), 64'd0);
    c_i = mk(1'b1, 3'd3, 32'h33);
    cyc();
    c_i_v = 1'b0;
    chk("legal_in", 64'(in_cnt), 64'd12);
    cyc();
    chk("legal_o", 64'(o), 64'(mk(1'b1, 3'd3, 32'h33)));
    cyc();
    chk("legal_out", 64'(out_cnt), 64'd12);
    c_i = mk(1'b0, 3'd7, 32'h77); c_i_v = 1'b1;
    cyc();
    c_i_v = 1'b0;
    repeat (2) cyc();
    chk("ill7_drop", 64'(drop_cnt), 64'd2);
    chk("ill7_err", 64'(err), 64'd1);
    chk("ill7_empty", 64'(empty), 64'd1);

    // destination == N on the N=3 instance
    c3_i = mk(1'b0, 3'd3, 32'h3); c3_v = 1'b1;
    cyc();
    chk("n3_drop", 64'(drop3_cnt), 64'd1);
    chk("n3_err", 64'(err3), 64'd1);
    chk("n3_in0", 64'(in3_cnt), 64'd0);
    c3_i = mk(1'b0, 3'd2, 32'h22);
    cyc();
    c3_v = 1'b0;
    chk("n3_in1", 64'(in3_cnt), 64'd1);
    chk("n3_lat", 64'(o3_v), 64'd0);
    cyc();
    chk("n3_o", 64'(o3), 64'(mk(1'b0, 3'd2, 32'h22)));
    cyc();
    chk("n3_out", 64'(out3_cnt), 64'd1);
    chk("n3_err_sticky", 64'(err3), 64'd1);

    // reset with three packets queued behind a stalled router
    o_bp = 1'b1; c_i_v = 1'b1;
    for (int j = 0; j < 3; j++) begin
      c_i = mk(1'b0, 3'(j), 32'h40 + 32'(j));
      cyc();
    end
    chk("pre_rst_in", 64'(in_cnt), 64'd15);
    c_i_v = 1'b0; rst = 1'b1;
    cyc();
    exp_q.delete();
    rst = 1'b0;
    chk("mid_rst_ov", 64'(o_v), 64'd0);
    chk("mid_rst_o", 64'(o), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_cnts", 64'(in_cnt | out_cnt | drop_cnt | stall_cnt), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_err3", 64'(err3), 64'd0);
    chk("mid_rst_bp", 64'(c_i_bp), 64'd0);
    r_pkt = mk(1'b1, 3'd2, 32'h55);
    o_bp = 1'b0; c_i = r_pkt; c_i_v = 1'b1;
    cyc();
    c_i_v = 1'b0;
    chk("post_rst_lat", 64'(o_v), 64'd0);
    chk("post_rst_in", 64'(in_cnt), 64'd1);
    cyc();
    chk("post_rst_o", 64'(o), 64'(r_pkt));
    cyc();
    chk("post_rst_out", 64'(out_cnt), 64'd1);
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
